// File: rtl/skinny_ctrl.sv
// skinny_ctrl: SKINNY-128-384 control FSM (load beats, round loop with rc LFSR, unload beats, done pulse).
// Optional stall support via `SKINNY_CTRL_STALL_EN (adds the hold input).
module skinny_ctrl #(
    parameter int ROUNDS = 56
) (
    input  logic       clock,
    input  logic       reset,
`ifdef SKINNY_CTRL_STALL_EN
    input  logic       hold,
`endif
    input  logic       start,
    output logic       load_en,
    output logic [3:0] load_idx,
    output logic       round_en,
    output logic [5:0] round_idx,
    output logic [5:0] rc,
    output logic       last_round,
    output logic       out_valid,
    output logic [3:0] out_idx,
    output logic       done,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UNLOAD, DONE} state_t;
    localparam logic [5:0] LAST = 6'(ROUNDS - 1);
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] round_q, round_d;
    logic [5:0] rc_q, rc_d;
    logic       stall;
`ifdef SKINNY_CTRL_STALL_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif
    // state, shared beat counter, round counter and rc LFSR
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            round_q <= 6'd0;
            rc_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            rc_q    <= rc_d;
        end
    end
    // next state; the beat counter wraps to 0 after beat 15, so it reads 0 in ROUND/DONE/IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        rc_d    = rc_q;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    state_d = start ? LOAD : IDLE;
                    cnt_d   = start ? 4'd1 : cnt_q;
                end
                LOAD: begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd15) ? ROUND : LOAD;
                    round_d = (cnt_q == 4'd15) ? 6'd0 : round_q;
                    rc_d    = (cnt_q == 4'd15) ? 6'h01 : rc_q;
                end
                ROUND: begin
                    state_d = (round_q == LAST) ? UNLOAD : ROUND;
                    round_d = (round_q == LAST) ? round_q : round_q + 6'd1;
                    rc_d    = (round_q == LAST) ? rc_q : {rc_q[4:0], ~(rc_q[5] ^ rc_q[4])};
                end
                UNLOAD: begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd15) ? DONE : UNLOAD;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // outputs; enables are gated by stall, indices simply mirror the counters
    always_comb begin
        load_en    = !stall && (state_q == LOAD || (state_q == IDLE && start));
        round_en   = !stall && state_q == ROUND;
        last_round = round_en && round_q == LAST;
        out_valid  = !stall && state_q == UNLOAD;
        done       = !stall && state_q == DONE;
        busy       = state_q != IDLE;
        load_idx   = cnt_q;
        out_idx    = cnt_q;
        round_idx  = round_q;
        rc         = rc_q;
    end
endmodule
